// File: rtl/soundbar_level_ctrl.sv
// Peak-window level meter for the OLED soundbar: peak detection per sample window,
// instant-attack / slow-decay smoothing, and a thermometer code committed only at frame start.
module soundbar_level_ctrl #(
  parameter int WINDOW        = 4000,
  parameter int DECAY_WINDOWS = 4,
  parameter int BASE          = 2048
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] mic_in,
  input  logic        sample_valid,
  input  logic        freeze,
  input  logic [12:0] index,
  output logic [15:0] tester,
  output logic [4:0]  level,
  output logic        window_done
);

  localparam int CW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int DW = (DECAY_WINDOWS > 2) ? $clog2(DECAY_WINDOWS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);
  localparam logic [DW-1:0] DEC_LAST = DW'(DECAY_WINDOWS - 1);
  localparam logic [12:0]   BASE_W   = 13'(BASE);

  logic [11:0]   peak_q, peak_d;
  logic [11:0]   peak_final_q, peak_final_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] decay_q, decay_d;
  logic [4:0]    level_q, level_d;
  logic [15:0]   tester_q, tester_d;
  logic          close_q, close_d;
  logic          pending_q, pending_d;

  logic          accept;
  logic [11:0]   sample_max;
  logic [12:0]   excess;
  logic [12:0]   rounded;
  logic [4:0]    target;
  logic [16:0]   therm;

  // sample_valid is a one-cycle strobe with no back-pressure: a sample is consumed
  // on every edge where sample_valid=1 and freeze=0, otherwise it is dropped.
  always_comb begin
    peak_d       = peak_q;
    peak_final_d = peak_final_q;
    cnt_d        = cnt_q;
    decay_d      = decay_q;
    level_d      = level_q;
    tester_d     = tester_q;
    pending_d    = pending_q;
    close_d      = freeze ? close_q : 1'b0;

    accept     = sample_valid & ~freeze;
    sample_max = ((cnt_q == '0) || (mic_in > peak_q)) ? mic_in : peak_q;

    excess  = ({1'b0, peak_final_q} > BASE_W) ? ({1'b0, peak_final_q} - BASE_W) : 13'd0;
    rounded = (excess + 13'd127) >> 7;
    target  = (rounded > 13'd16) ? 5'd16 : rounded[4:0];
    therm   = (17'd1 << level_q) - 17'd1;

    if (accept) begin
      peak_d = sample_max;
      if (cnt_q == CNT_LAST) begin
        cnt_d        = '0;
        peak_final_d = sample_max;
        close_d      = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (!freeze) begin
      // Frame commit reads the pre-update level, so a collision shows the old bar.
      if (pending_q && (index == '0)) begin
        tester_d  = therm[15:0];
        pending_d = 1'b0;
      end
      if (close_q) begin
        pending_d = 1'b1;
        if (target >= level_q) begin
          level_d = target;
          decay_d = '0;
        end else if (decay_q < DEC_LAST) begin
          decay_d = decay_q + 1'b1;
        end else begin
          level_d = level_q - 5'd1;
          decay_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      peak_q       <= '0;
      peak_final_q <= '0;
      cnt_q        <= '0;
      decay_q      <= '0;
      level_q      <= '0;
      tester_q     <= '0;
      close_q      <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      peak_q       <= peak_d;
      peak_final_q <= peak_final_d;
      cnt_q        <= cnt_d;
      decay_q      <= decay_d;
      level_q      <= level_d;
      tester_q     <= tester_d;
      close_q      <= close_d;
      pending_q    <= pending_d;
    end
  end

  assign tester      = tester_q;
  assign level       = level_q;
  assign window_done = close_q & ~freeze;

endmodule

// File: doc/soundbar_level_ctrl.md
Name: soundbar_level_ctrl

Overview:
- Sequencer that drives the 16-bit thermometer level code consumed by the OLED soundbar renderer.
- Tracks peak microphone amplitude over fixed sample windows and converts it to a 0..16 level.
- Applies instant-attack / slow-decay smoothing.
- Commits the new code only at a frame boundary (pixel index 0), so the 96x64 bar never tears mid-frame.

Parameters:
- WINDOW, 4000, samples per peak window (>=2).
- DECAY_WINDOWS, 4, windows per one-step fall of the displayed level (>=1).
- BASE, 2048, mic zero-signal midpoint; samples at or below BASE count as silence.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mic_in  in  12  unsigned mic sample.
- sample_valid  in  1  one-cycle strobe: mic_in valid this cycle.
- freeze  in  1  high = ignore samples, hold all state and outputs.
- index  in  13  current OLED pixel index (0..6143), from the display driver.
- tester  out  16  thermometer code, LSB-first; level L gives the low L bits set.
- level  out  5  displayed level 0..16 (pending value, pre frame-sync).
- window_done  out  1  one-cycle pulse when a window closes.

Behaviour:
- Reset (synchronous, active-high): tester=0, level=0, window_done=0, peak=0, sample count=0, decay count=0, pending=0.
- Sampling: each cycle with sample_valid=1 and freeze=0, the sample is accepted.
  - First sample of a window loads peak := mic_in; later samples use peak := max(peak, mic_in).
  - Sample counter counts 0..WINDOW-1.
- Window close: the accepted sample that brings the count to WINDOW-1 is included in the peak.
  - Same edge: peak_final := resulting peak; counter wraps to 0; window_done pulses on the following cycle (T+1).
  - The next accepted sample starts a fresh window, even if it arrives at T+1.
- Target level, computed combinationally from peak_final in cycle T+1:
  - excess = (peak_final > BASE) ? peak_final - BASE : 0.
  - target = min(16, (excess + 127) >> 7).
  - Examples: excess 0 -> 0; 1..128 -> 1; 1921..2047 -> 16.
- Smoothing, registered at the end of T+1, so level is valid at T+2:
  - target >= level: level := target; decay count := 0.
  - Otherwise, decay count < DECAY_WINDOWS-1: decay count += 1; level unchanged.
  - Otherwise: level := level-1; decay count := 0.
  - level never underflows below 0 or exceeds 16.
  - Every window close sets pending := 1.
- Frame sync: on a cycle with pending=1 and index==0, tester := (1<<level)-1 (17-bit arithmetic, truncated to 16 bits; level 16 gives 16'hFFFF), and pending := 0.
  - tester is registered: it changes one cycle after index==0 is sampled.
  - tester never changes at any other time.
  - If index==0 coincides with the cycle level updates, the old level is committed and pending stays 1 for the next frame.
- freeze=1: sample_valid ignored; counters, peak, level, pending and tester all hold; no window_done. Releasing freeze resumes mid-window.
- Simultaneous sample_valid and window close: the closing sample counts in the closing window only.
- Mid-operation reset: everything returns to reset values on the next edge; a partial window is discarded.

Test Plan (WINDOW=4, DECAY_WINDOWS=2, BASE=2048):
- Reset: reset=1 for 2 cycles with samples of 4095 -> tester=0, level=0, no window_done.
- Attack: 4 samples {2100, 4095, 2000, 2048}, index held at 5 -> window_done pulses at T+1, level=16 at T+2, tester stays 0; drive index=0 -> tester=16'hFFFF one cycle later.
- Decay: then windows with max 2048 (silence) -> level 16, 15 (after 2nd window), 15, 14 (after 4th); tester at each frame start = 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h3FFF.
- Quantisation: single windows with peaks 2049, 2176, 2177, 2000 from level 0 -> targets 1, 1, 2, 0; tester 16'h0001, 16'h0001, 16'h0003.
- Frame sync collision: index==0 asserted in the same cycle level updates from 3 to 7 -> tester keeps 16'h0007 (old level 3) this frame; next index==0 -> 16'h007F.
- Freeze and reset: 2 samples of 3000, freeze=1, 5 strobes of 4095, freeze=0, 2 samples of 2048 -> peak 3000, target 8, tester 16'h00FF at next frame start. Repeat with reset pulsed after the first 2 samples -> no window_done until 4 further samples arrive.
